// File: rtl/window_frame_sequencer_pkg.sv
// Shared types and constants for the windowing sequencer (package window_pkg).
// Optional feature macro used by the sequencer: WINDOW_SEQ_BYPASS_EN.
package window_pkg;

    // Window coefficients are unsigned Q1.15; 0x8000 represents exactly 1.0.
    localparam int COEFF_WIDTH     = 16;
    localparam int COEFF_FRAC_BITS = 15;
    localparam logic [COEFF_WIDTH-1:0] COEFF_UNITY = 16'h8000;

    localparam real PI = 3.141592653589793;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } win_seq_state_t;

    // Round a real window weight in [0,1] to the nearest Q1.15 code.
    function automatic int quantize_coeff(real weight);
        return $rtoi(weight * (2.0 ** COEFF_FRAC_BITS) + 0.5);
    endfunction

endpackage

// File: rtl/window_frame_sequencer_if.sv
// Frame RAM read port and windowed-sample output stream of the sequencer.
// master: the sequencer; slave: the RAM / downstream consumer side.
interface window_frame_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                         mem_rd_en;
    logic [ADDR_WIDTH-1:0]        mem_rd_addr;
    logic signed [DATA_WIDTH-1:0] mem_rd_data;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_last;
    logic                         out_ready;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/window_frame_sequencer_coeff_rom.sv
// window_coeff_rom: window coefficient table built at elaboration time,
// read through a registered port with enable (1-cycle latency, holds when idle).
// Periodic windows (denominator FRAME_SIZE) so the peak lands exactly on 1.0.
module window_coeff_rom
    import window_pkg::*;
#(
    parameter int    FRAME_SIZE  = 256,
    parameter string WINDOW_TYPE = "hamming",
    parameter int    ADDR_WIDTH  = $clog2(FRAME_SIZE)
) (
    input  logic                   clk,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [COEFF_WIDTH-1:0] rd_data
);

    logic [COEFF_WIDTH-1:0] table_rom [FRAME_SIZE];

    for (genvar gi = 0; gi < FRAME_SIZE; gi++) begin : g_coeff
        localparam real THETA  = 2.0 * PI * gi / FRAME_SIZE;
        localparam real WEIGHT =
            (WINDOW_TYPE == "hann")     ? 0.5 - 0.5 * $cos(THETA) :
            (WINDOW_TYPE == "hamming")  ? 0.54 - 0.46 * $cos(THETA) :
            (WINDOW_TYPE == "blackman") ? 0.42 - 0.5 * $cos(THETA) + 0.08 * $cos(2.0 * THETA) :
                                          1.0;
        localparam int QUANT = quantize_coeff(WEIGHT);
        // Clamp so rounding can never exceed the 1.0 code.
        assign table_rom[gi] = (QUANT >= (1 << COEFF_FRAC_BITS)) ? COEFF_UNITY
                                                                 : QUANT[COEFF_WIDTH-1:0];
    end

    // Registered read; output holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= table_rom[rd_addr];
        end
    end

endmodule

// File: rtl/window_frame_sequencer.sv
// window_frame_sequencer: walks a frame buffer, multiplies each sample by its
// window coefficient on one shared multiplier and streams the result out with
// valid/ready backpressure. Optional macro WINDOW_SEQ_BYPASS_EN adds cfg_bypass
// (per-frame unity coefficient).
module window_frame_sequencer
    import window_pkg::*;
#(
    parameter int    DATA_WIDTH  = 16,
    parameter int    FRAME_SIZE  = 256,
    parameter int    ADDR_WIDTH  = $clog2(FRAME_SIZE),
    parameter string WINDOW_TYPE = "hamming"
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
`ifdef WINDOW_SEQ_BYPASS_EN
    input  logic cfg_bypass,
`endif
    output logic busy,
    output logic done,
    output logic frame_overrun,
    window_frame_sequencer_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_SIZE - 1);
    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH + 1;

    win_seq_state_t state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic advance, issue, issue_last, start_accept, done_next;
    logic overrun_reg;

    // Pipeline: stage1 = RAM/ROM data, stage2 = product, stage3 = output register
    logic v1_reg, l1_reg, v2_reg, l2_reg;
    logic signed [PROD_WIDTH-1:0] prod_reg, data_ext, coeff_ext;
    logic signed [DATA_WIDTH-1:0] out_data_reg;
    logic out_valid_reg, out_last_reg;
    logic [COEFF_WIDTH-1:0] rom_coeff, coeff;

    // Every stage moves together; a held output freezes the whole pipe.
    assign advance    = !out_valid_reg || bus.out_ready;
    assign issue_last = issue && (addr_reg == LAST_ADDR);

    window_coeff_rom #(
        .FRAME_SIZE  (FRAME_SIZE),
        .WINDOW_TYPE (WINDOW_TYPE),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_coeff_rom (
        .clk     (clk),
        .rd_en   (issue),
        .rd_addr (addr_reg),
        .rd_data (rom_coeff)
    );

`ifdef WINDOW_SEQ_BYPASS_EN
    logic bypass_reg;

    // Bypass choice is latched once per frame, when the frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_reg <= 1'b0;
        end else if (start_accept) begin
            bypass_reg <= cfg_bypass;
        end
    end

    assign coeff = bypass_reg ? COEFF_UNITY : rom_coeff;
`else
    assign coeff = rom_coeff;
`endif

    // Next-state logic: issue addresses in RUN, wait for the last accept in DRAIN.
    always_comb begin
        state_next   = state_reg;
        issue        = 1'b0;
        start_accept = 1'b0;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    start_accept = 1'b1;
                    state_next   = RUN;
                end
            end
            RUN: begin
                issue = advance;
                if (advance && (addr_reg == LAST_ADDR)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_reg && out_last_reg && bus.out_ready) begin
                    done_next = 1'b1;
                    // A new frame may start in the very cycle the old one finishes.
                    if (frame_start) begin
                        start_accept = 1'b1;
                        state_next   = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, address counter (wraps to 0 after the last address) and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            overrun_reg <= frame_start && (state_reg != IDLE) && !start_accept;
            if (issue) begin
                addr_reg <= addr_reg + 1'b1;
            end
        end
    end

    assign data_ext  = PROD_WIDTH'(bus.mem_rd_data);
    assign coeff_ext = PROD_WIDTH'({1'b0, coeff});

    // Data pipeline: all stages advance in lock-step under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg        <= 1'b0;
            l1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            l2_reg        <= 1'b0;
            prod_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (advance) begin
            v1_reg        <= issue;
            l1_reg        <= issue_last;
            v2_reg        <= v1_reg;
            l2_reg        <= l1_reg;
            prod_reg      <= data_ext * coeff_ext;
            out_valid_reg <= v2_reg;
            out_last_reg  <= l2_reg;
            // Arithmetic shift by the coefficient fraction bits (floor), then truncate.
            if (v2_reg) begin
                out_data_reg <= prod_reg[COEFF_FRAC_BITS +: DATA_WIDTH];
            end
        end
    end

    // Product bits outside the output window are intentionally discarded.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod_reg[PROD_WIDTH-1:COEFF_FRAC_BITS+DATA_WIDTH],
                                prod_reg[COEFF_FRAC_BITS-1:0]};

    assign busy            = (state_reg != IDLE);
    assign done            = done_next;
    assign frame_overrun   = overrun_reg;
    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = addr_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_last    = out_last_reg;

endmodule

// File: tb/tb_window_frame_sequencer.sv
// Scoreboard bench for window_frame_sequencer (FRAME_SIZE=8, Hann window).
// Expected samples are queued when a frame is launched and checked on accept.
module tb_window_frame_sequencer;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 3;

    // Periodic Hann, N=8, rounded to Q1.15: 0.5-0.5*cos(2*pi*n/8) * 32768
    int hann_q [N] = '{0, 4799, 16384, 27969, 32768, 27969, 16384, 4799};

    typedef struct {
        int data;
        bit last;
    } exp_t;
    exp_t sb_q[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic busy, done, frame_overrun;
`ifdef WINDOW_SEQ_BYPASS_EN
    logic cfg_bypass = 1'b0;
`endif

    window_frame_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    window_frame_sequencer #(
        .DATA_WIDTH  (DW),
        .FRAME_SIZE  (N),
        .ADDR_WIDTH  (AW),
        .WINDOW_TYPE ("hann")
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
`ifdef WINDOW_SEQ_BYPASS_EN
        .cfg_bypass    (cfg_bypass),
`endif
        .busy          (busy),
        .done          (done),
        .frame_overrun (frame_overrun),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame RAM model: 1-cycle read latency, data held when not enabled
    logic signed [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    int  tests_run = 0;
    int  tests_failed = 0;
    int  accept_cnt = 0;
    int  done_cnt = 0;
    int  ovr_cnt = 0;
    int  done_cyc = 0;
    int  exp_addr = 0;
    bit  rand_ready = 0;
    bit  prev_stall = 0;
    logic signed [DW-1:0] prev_data;
    logic prev_last;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int d, input int c);
        longint p;
        p = longint'(d) * longint'(c);
        return int'(p >>> 15);
    endfunction

    // Output monitor: scoreboard pops, stall stability, address order, pulses
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr   = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", bus.out_valid, 1);
                check_eq("stall_data", bus.out_data, prev_data);
                check_eq("stall_last", bus.out_last, prev_last);
            end
            if (bus.mem_rd_en) begin
                check_eq("rd_addr", bus.mem_rd_addr, exp_addr);
                exp_addr = (exp_addr + 1) % N;
            end
            if (bus.out_valid && bus.out_ready) begin
                accept_cnt++;
                check_eq("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("[TB] cyc %0d accept data=%0d last=%0d (exp %0d/%0d)",
                             cyc, bus.out_data, bus.out_last, e.data, e.last);
                    check_eq("out_data", bus.out_data, e.data);
                    check_eq("out_last", bus.out_last, e.last);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("done_on_last_accept", bus.out_valid && bus.out_ready && bus.out_last, 1);
            end
            if (frame_overrun) ovr_cnt++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // kind: 0 ramp n*1000, 1 constant 0x7FFF, 2 constant -32768
    task automatic run_frame(input int kind, input bit rnd, input int ovr_at,
                             input int rst_at, input bit byp);
        int a0, d0, o0, start_c, rel, waited, d;
        bit ended, aborted;
        for (int n = 0; n < N; n++) begin
            d = (kind == 0) ? n * 1000 : (kind == 1) ? 32767 : -32768;
            mem[n] = DW'(d);
            sb_q.push_back('{model(d, byp ? 32768 : hann_q[n]), n == N - 1});
        end
        a0 = accept_cnt; d0 = done_cnt; o0 = ovr_cnt;
        rand_ready = rnd;
`ifdef WINDOW_SEQ_BYPASS_EN
        cfg_bypass = byp;
`endif
        frame_start = 1'b1;
        start_c = cyc;
        step();
        frame_start = 1'b0;
`ifdef WINDOW_SEQ_BYPASS_EN
        cfg_bypass = 1'b0;
`endif
        ended = 0; aborted = 0; waited = 0;
        while (!ended && waited < 300) begin
            rel = cyc - start_c;
            frame_start = (ovr_at >= 0 && rel == ovr_at);
            if (rst_at >= 0 && rel == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_eq("rst_outputs_zero",
                            {busy, done, frame_overrun, bus.mem_rd_en, bus.mem_rd_addr,
                             bus.out_valid, bus.out_last, bus.out_data}, 0);
                sb_q.delete();
                frame_start = 1'b0;
                step(); step();
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    step();
                    check_eq("post_rst_quiet", {bus.out_valid, done, busy}, 0);
                end
                ended = 1; aborted = 1;
            end else begin
                step();
                waited++;
                if (done_cnt != d0) ended = 1;
            end
        end
        frame_start = 1'b0;
        if (!aborted) begin
            check_eq("done_seen", ended, 1);
            if (!rnd) check_eq("done_latency", done_cyc - start_c, N + 3);
            repeat (4) step();
            check_eq("accepts", accept_cnt - a0, N);
            check_eq("done_count", done_cnt - d0, 1);
            check_eq("overrun_count", ovr_cnt - o0, (ovr_at >= 0) ? 1 : 0);
            check_eq("sb_drained", sb_q.size(), 0);
        end
        rand_ready = 0;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        repeat (3) step();
        check_eq("reset_outputs",
                 {busy, done, frame_overrun, bus.mem_rd_en, bus.mem_rd_addr,
                  bus.out_valid, bus.out_last, bus.out_data}, 0);
        rst_n = 1'b1;
        step();

        run_frame(0, 0, -1, -1, 0);   // ramp, full throughput
        run_frame(1, 0, -1, -1, 0);   // 0x7FFF through Hann
        run_frame(0, 1, -1, -1, 0);   // random backpressure
        run_frame(1, 1, -1, -1, 0);
        run_frame(0, 0, 4, -1, 0);    // frame_start while busy
        run_frame(0, 0, -1, 4, 0);    // reset mid-frame
        run_frame(0, 0, -1, -1, 0);   // clean frame after reset
        run_frame(2, 0, -1, -1, 0);   // most negative sample
`ifdef WINDOW_SEQ_BYPASS_EN
        run_frame(2, 0, -1, -1, 1);   // bypass: unity coefficient
        run_frame(2, 1, -1, -1, 0);   // bypass cleared for next frame
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
